data_sram_responder: RTL
========================

# data_sram_responder

Responder (slave) end of the data-side SRAM-like req/addr_ok/data_ok protocol driven by the Execute stage. It accepts byte-strobed writes and word reads into an internal word-addressed memory and returns `data_ok`/`rdata` a fixed number of cycles after each accepted request. Outstanding requests are limited by a parameter. It serves as the data memory model for core-level simulation and as the on-chip scratchpad behind the pipeline's data port.

## Interface
- `ADDR_W`, 16: byte-address bits decoded; memory holds 2^(ADDR_W-2) 32-bit words; upper address bits are ignored.
- `LATENCY`, 1: cycles from accept to `data_ok`; legal range 1..8.
- `MAX_OUT`, 2: maximum accepted requests without a returned `data_ok`; legal range 1..8.
- Reset is synchronous and active-high, and the block runs on one clock.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_sram_req` input 1: request valid.
- `data_sram_wr` input 1: 1 = write, 0 = read.
- `data_sram_size` input 2: 0 = byte, 1 = half, 2 = word. Informational only; `wstrb` is authoritative.
- `data_sram_wstrb` input 4: byte enables for a write.
- `data_sram_addr` input 32: byte address; word index is `addr[ADDR_W-1:2]`.
- `data_sram_wdata` input 32: write data, already lane-replicated by the initiator.
- `data_sram_addr_ok` output 1: request accepted this cycle.
- `data_sram_data_ok` output 1: one response completes this cycle.
- `data_sram_rdata` output 32: read word; 0 for write responses.

## Operation
- **Accept:** a request is accepted in a cycle where `req && addr_ok`.
- **addr_ok:** `addr_ok = req && (out_cnt != MAX_OUT) && !stall`. `stall` is 0 unless the macro is defined.
- **Writes:** performed in the accept cycle. `mem[idx][8k+7:8k] <= wdata[8k+7:8k]` for each set `wstrb[k]`. A write with `wstrb == 0` still completes with `data_ok`.
- **Reads:** memory is sampled in the accept cycle, so a read sees every previously accepted write, including a write accepted in the previous cycle.
- **Response pipeline:** `LATENCY`-stage shift register of `{valid, rdata}`. Stage 0 loads on accept. The last stage drives `data_ok`/`rdata`. At most one accept per cycle, so responses are in order and at most one `data_ok` fires per cycle.
- **out_cnt:** width `clog2(MAX_OUT+1)`.
  - +1 on accept; -1 on `data_ok`; unchanged when both occur.
  - When full, `addr_ok` stays low even if `data_ok` fires the same cycle (no pass-through).
- **No data back-pressure:** the initiator must always take `data_ok`.
- **Reset:** clears the pipeline valids, `out_cnt`, `data_ok` (0), `rdata` (0) and the LFSR.
  - Memory contents are retained.
  - In-flight requests are dropped; no `data_ok` is issued for them after reset.
  - Requests presented during `rst` get `addr_ok = 0`.

## Timing
- `addr_ok` is combinational from `req` and registered state, so it is valid in the same cycle as `req`.
- `data_ok` and `rdata` are registered.
- Accept at cycle T gives `data_ok` at T+LATENCY, with `rdata` valid in that cycle only.
- Peak throughput is one request per cycle when `MAX_OUT > LATENCY`.
- When `MAX_OUT <= LATENCY`, throughput is `MAX_OUT/(LATENCY+1)`.
- Default `LATENCY=1`, `MAX_OUT=2` gives back-to-back accepts every cycle.
- Releasing reset at cycle R: `addr_ok` may assert at R+1.

## Configuration
- `DSRAM_RESP_STALL_EN` defined: adds an 8-bit Fibonacci LFSR.
  - Taps x^8+x^6+x^5+x^4+1; reset value 8'hA5.
  - Advances every non-reset cycle.
  - `stall = lfsr[0]` gates `addr_ok` low, giving pseudo-random back-pressure so initiator retry logic is exercised.
  - `data_ok` timing is unaffected.
- Not defined: no LFSR logic; `stall` is tied to 0.

## Test plan
- Macro off, defaults: write `addr=0x10`, `wstrb=4'b1111`, `wdata=0x12345678` at T → `addr_ok` at T, `data_ok` at T+1 with `rdata=0`. Read `0x10` at T+1 → `data_ok` at T+2 with `rdata=0x12345678`.
- Byte write `addr=0x11`, `wstrb=4'b0010`, `wdata=0xABABABAB` over word `0x12345678`, then read `0x10` → `rdata=0x1234AB78`.
- Defaults with `req` held high for 4 reads: `addr_ok` high 4 consecutive cycles, 4 `data_ok` pulses in order, `out_cnt` never above 1.
- `LATENCY=3`, `MAX_OUT=2`, `req` held: accepts at T and T+1; `addr_ok` low T+2..T+3; `data_ok` at T+3 and T+4; next accept at T+4.
- Two reads accepted, `rst` asserted one cycle before the first `data_ok` → no `data_ok` after reset; memory still holds prior writes.
- Macro on, `req` held every cycle after reset → `addr_ok` follows `!lfsr[0]` starting from seed 8'hA5 (first cycle low). Every accepted request gets exactly one `data_ok`, LATENCY cycles later.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: byte-strobed writes and word reads with fixed-latency, in-order data_ok.
// Define DSRAM_RESP_STALL_EN to add LFSR-driven pseudo-random addr_ok back-pressure.
module data_sram_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int WORDS = 1 << (ADDR_W - 2);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [31:0]       mem_q [WORDS];
    logic [ADDR_W-3:0] word_idx;
    logic              stall;
    logic              accept;
    logic              resp_fire;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [CNT_W-1:0]  out_cnt_d;
    logic [LATENCY-1:0] vld_q;
    logic [31:0]       dat_q [LATENCY];

    // Size and the undecoded address bits carry no behaviour; wstrb is authoritative.
    logic unused_ok;
    assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_W], data_sram_addr[1:0]};

    assign word_idx = data_sram_addr[ADDR_W-1:2];

`ifdef DSRAM_RESP_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // A full counter blocks acceptance even when a response retires this cycle.
    assign data_sram_addr_ok = data_sram_req && !rst && (out_cnt_q != CNT_MAX) && !stall;
    assign accept            = data_sram_addr_ok;
    assign resp_fire         = vld_q[LATENCY-1];

    always_comb begin
        // NOTE: default first so every path assigns out_cnt_d and no latch is inferred.
        out_cnt_d = out_cnt_q;
        if (accept && !resp_fire) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!accept && resp_fire) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q <= '0;
            vld_q     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            out_cnt_q <= out_cnt_d;
            vld_q[0]  <= accept;
            dat_q[0]  <= (accept && !data_sram_wr) ? mem_q[word_idx] : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    // NOTE: memory has no reset; contents survive rst and reads of unwritten words are undefined.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (data_sram_wstrb[k]) begin
                    mem_q[word_idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
                end
            end
        end
    end

    assign data_sram_data_ok = vld_q[LATENCY-1];
    assign data_sram_rdata   = dat_q[LATENCY-1];

endmodule
